// File: rtl/rggen_irq_coalescer.sv
// Interrupt coalescer for a bank of W1C status fields: forwards event
// pulses as field sets and raises one irq on an event-count threshold or timeout.
module rggen_irq_coalescer #(
    parameter int SOURCES     = 8,
    parameter int COUNT_WIDTH = 8,
    parameter int TIMER_WIDTH = 16
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic [SOURCES-1:0]     i_event,
    output logic [SOURCES-1:0]     o_set,
    input  logic [SOURCES-1:0]     i_status,
    input  logic [SOURCES-1:0]     i_enable,
    input  logic                   i_coalesce_en,
    input  logic [COUNT_WIDTH-1:0] i_threshold,
    input  logic [TIMER_WIDTH-1:0] i_timeout,
    output logic                   o_irq,
    output logic [COUNT_WIDTH-1:0] o_event_count,
    output logic [1:0]             o_state
);

    localparam logic [1:0] IDLE   = 2'd0;
    localparam logic [1:0] WAIT   = 2'd1;
    localparam logic [1:0] ASSERT = 2'd2;

    // six extra bits hold a popcount of up to 32 sources on top of the counter
    localparam int SUM_W = COUNT_WIDTH + 6;
    localparam logic [SUM_W-1:0] CNT_MAX = {{6{1'b0}}, {COUNT_WIDTH{1'b1}}};

    logic [1:0]             state;
    logic [1:0]             state_next;
    logic [COUNT_WIDTH-1:0] count;
    logic [COUNT_WIDTH-1:0] count_next;
    logic [TIMER_WIDTH-1:0] timer;
    logic [TIMER_WIDTH-1:0] timer_next;
    logic                   irq;
    logic                   pending;
    logic                   thr_met;
    logic                   tmo_met;
    logic                   to_idle;
    logic [SOURCES-1:0]     hits;
    logic [5:0]             inc;
    logic [SUM_W-1:0]       base;
    logic [SUM_W-1:0]       sum;

    assign o_set         = i_event;
    assign o_irq         = irq;
    assign o_event_count = count;
    assign o_state       = state;

    assign pending = |(i_status & i_enable);
    assign hits    = i_event & i_enable;
    assign thr_met = count >= i_threshold;
    assign tmo_met = timer >= i_timeout;

    always_comb begin
        inc = '0;
        for (int i = 0; i < SOURCES; i++) begin
            inc = inc + 6'(hits[i]);
        end
    end

    always_comb begin
        state_next = state;
        case (state)
            IDLE: begin
                if (pending) begin
                    state_next = i_coalesce_en ? WAIT : ASSERT;
                end
            end
            WAIT: begin
                // losing pending wins over a threshold/timeout hit
                if (!pending) begin
                    state_next = IDLE;
                end else if (thr_met || tmo_met) begin
                    state_next = ASSERT;
                end
            end
            ASSERT: begin
                if (!pending) begin
                    state_next = IDLE;
                end
            end
            default: state_next = IDLE;
        endcase
    end

    assign to_idle = (state_next == IDLE) && (state != IDLE);

    always_comb begin
        base       = to_idle ? '0 : SUM_W'(count);
        sum        = base + SUM_W'(inc);
        count_next = (sum > CNT_MAX) ? {COUNT_WIDTH{1'b1}}
                                     : sum[COUNT_WIDTH-1:0];
    end

    always_comb begin
        timer_next = '0;
        if (state == WAIT && state_next == WAIT) begin
            timer_next = (&timer) ? timer : timer + TIMER_WIDTH'(1);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
            count <= '0;
            timer <= '0;
            irq   <= 1'b0;
        end else begin
            state <= state_next;
            count <= count_next;
            timer <= timer_next;
            irq   <= (state_next == ASSERT);
        end
    end

endmodule

// File: tb/tb_rggen_irq_coalescer.sv
// Directed bench for rggen_irq_coalescer with a W1C status field
// and enable register modelled alongside the DUT.
module tb_rggen_irq_coalescer;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic [7:0]  ev = '0;
    logic [7:0]  set;
    logic [7:0]  status;
    logic [7:0]  enable;
    logic        coal = 1'b0;
    logic [7:0]  thr = 8'd0;
    logic [15:0] tmo = 16'd0;
    logic        irq;
    logic [7:0]  cnt;
    logic [1:0]  st;

    logic [7:0]  sw_clr = '0;
    logic        en_we = 1'b0;
    logic [7:0]  en_wd = '0;

    int tests = 0;
    int fails = 0;

    always #5 clk = ~clk;

    rggen_irq_coalescer #(
        .SOURCES    (8),
        .COUNT_WIDTH(8),
        .TIMER_WIDTH(16)
    ) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .i_event      (ev),
        .o_set        (set),
        .i_status     (status),
        .i_enable     (enable),
        .i_coalesce_en(coal),
        .i_threshold  (thr),
        .i_timeout    (tmo),
        .o_irq        (irq),
        .o_event_count(cnt),
        .o_state      (st)
    );

    // W1C status fields: hw set, sw clear
    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) status <= '0;
        else        status <= (status | set) & ~sw_clr;
    end

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n)     enable <= '0;
        else if (en_we) enable <= en_wd;
    end

    task automatic chk(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
        tests++;
        if (obs !== exp) begin
            fails++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic wr_en(input logic [7:0] v);
        en_we = 1'b1;
        en_wd = v;
        tick();
        en_we = 1'b0;
    endtask

    task automatic sw_clear(input logic [7:0] v);
        sw_clr = v;
        tick();
        sw_clr = '0;
        tick();
    endtask

    logic seen;

    initial begin
        ev = 8'h5A;
        #1;
        chk("rst_set", set, 8'h5A);
        chk("rst_state", st, 0);
        chk("rst_irq", irq, 0);
        chk("rst_cnt", cnt, 0);
        tick();
        ev = '0;
        rst_n = 1'b1;
        tick();

        // non-coalesced
        wr_en(8'h01);
        coal = 1'b0;
        ev = 8'h01;
        #1;
        chk("nc_set", set, 8'h01);
        tick();
        ev = '0;
        chk("nc_t1_state", st, 0);
        chk("nc_t1_cnt", cnt, 1);
        tick();
        chk("nc_t2_irq", irq, 1);
        chk("nc_t2_state", st, 2);
        sw_clr = 8'h01;
        tick();
        sw_clr = '0;
        chk("nc_c1_irq", irq, 1);
        tick();
        chk("nc_c2_irq", irq, 0);
        chk("nc_c2_state", st, 0);
        chk("nc_c2_cnt", cnt, 0);

        // threshold
        wr_en(8'hFF);
        coal = 1'b1;
        thr = 8'd4;
        tmo = 16'd1000;
        ev = 8'h03;
        tick();
        chk("th_t1_cnt", cnt, 2);
        chk("th_t1_state", st, 0);
        tick();
        ev = '0;
        chk("th_t2_cnt", cnt, 4);
        chk("th_t2_state", st, 1);
        tick();
        chk("th_t3_state", st, 2);
        chk("th_t3_irq", irq, 1);
        chk("th_t3_cnt", cnt, 4);
        sw_clear(8'hFF);
        chk("th_clr_state", st, 0);
        chk("th_clr_cnt", cnt, 0);

        // timeout
        thr = 8'd200;
        tmo = 16'd10;
        ev = 8'h01;
        tick();
        ev = '0;
        tick();
        chk("to_w_state", st, 1);
        seen = 1'b0;
        for (int i = 0; i < 10; i++) begin
            tick();
            seen = seen | irq;
        end
        chk("to_w10_state", st, 1);
        chk("to_w10_irq", seen, 0);
        tick();
        chk("to_w11_state", st, 2);
        chk("to_w11_irq", irq, 1);
        chk("to_w11_cnt", cnt, 1);
        sw_clear(8'hFF);
        chk("to_clr_irq", irq, 0);

        // masking
        wr_en(8'h00);
        coal = 1'b0;
        ev = 8'hFF;
        #1;
        chk("mk_set", set, 8'hFF);
        tick();
        ev = '0;
        chk("mk_t1_cnt", cnt, 0);
        tick();
        chk("mk_t2_state", st, 0);
        chk("mk_t2_irq", irq, 0);
        en_we = 1'b1;
        en_wd = 8'h80;
        tick();
        en_we = 1'b0;
        chk("mk_e1_irq", irq, 0);
        tick();
        chk("mk_e2_irq", irq, 1);
        chk("mk_e2_cnt", cnt, 0);
        sw_clear(8'hFF);
        chk("mk_clr_state", st, 0);

        // saturation
        wr_en(8'hFF);
        ev = 8'hFF;
        for (int i = 0; i < 33; i++) tick();
        ev = '0;
        tick();
        chk("sat_cnt", cnt, 255);
        chk("sat_irq", irq, 1);
        sw_clear(8'hFF);
        chk("sat_clr_cnt", cnt, 0);

        // pending drop races timeout
        coal = 1'b1;
        thr = 8'd200;
        tmo = 16'd3;
        ev = 8'h01;
        tick();
        ev = '0;
        seen = 1'b0;
        tick();
        chk("race_w_state", st, 1);
        tick();
        seen = seen | irq;
        tick();
        seen = seen | irq;
        sw_clr = 8'h01;
        tick();
        sw_clr = '0;
        seen = seen | irq;
        chk("race_w3_state", st, 1);
        tick();
        seen = seen | irq;
        chk("race_w4_state", st, 0);
        tick();
        seen = seen | irq;
        chk("race_irq_seen", seen, 0);

        // async reset mid-ASSERT
        coal = 1'b0;
        ev = 8'h01;
        tick();
        ev = '0;
        tick();
        chk("ra_irq_pre", irq, 1);
        #2;
        rst_n = 1'b0;
        #1;
        chk("ra_irq", irq, 0);
        chk("ra_cnt", cnt, 0);
        chk("ra_state", st, 0);
        tick();
        rst_n = 1'b1;
        tick();
        tick();
        chk("ra_post_irq", irq, 0);
        chk("ra_post_state", st, 0);
        chk("ra_post_cnt", cnt, 0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
